// File: rtl/jk_mod_counter_if.sv
// Control and observation bundle for jk_mod_counter; master drives controls, slave returns state.
interface jk_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up, load, load_val,
        input  q, j_out, k_out, tc, wrap
    );

    modport slave (
        input  en, up, load, load_val,
        output q, j_out, k_out, tc, wrap
    );
endinterface

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter built from JK cells; q updates on the edge that samples inputs.
// No backpressure: one state update per clock, tc/j_out/k_out are combinational.
module jk_mod_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic            clk,
    input  logic            rst,
    jk_mod_counter_if.slave bus
);
    if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
        $error("jk_mod_counter: MOD=%0d outside 2..2**WIDTH (WIDTH=%0d)", MOD, WIDTH);
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] j_s, k_s;
    logic             at_end_s;
    logic             tc_s;
    logic             wrap_q, wrap_d;

    assign at_end_s = bus.up ? (q_q == MAX_V) : (q_q == '0);
    assign tc_s     = bus.en & ~bus.load & at_end_s;

    always_comb begin
        next_s = q_q;
        if (bus.load) begin
            // Out-of-range loads saturate so q never leaves 0..MOD-1.
            next_s = ({1'b0, bus.load_val} < MOD_W) ? bus.load_val : MAX_V;
        end else if (bus.en && bus.up) begin
            next_s = (q_q == MAX_V) ? '0 : q_q + 1'b1;
        end else if (bus.en) begin
            next_s = (q_q == '0) ? MAX_V : q_q - 1'b1;
        end
    end

    // Excitation with don't-cares tied low: J only sets a 0 cell, K only clears a 1 cell.
    always_comb begin
        j_s    = next_s & ~q_q;
        k_s    = ~next_s & q_q;
        q_d    = (j_s & ~q_q) | (~k_s & q_q);
        wrap_d = tc_s;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.j_out = j_s;
    assign bus.k_out = k_s;
    assign bus.tc    = tc_s;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter (WIDTH=4, MOD=10) with a reference model and expected-result queue.
module tb_jk_mod_counter;
    localparam int WIDTH = 4;
    localparam int MOD   = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jk_mod_counter_if #(.WIDTH(WIDTH)) bus ();
    jk_mod_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int q;
        bit w;
    } exp_t;

    exp_t sb[$];
    int vectors     = 0;
    int miscompares = 0;
    int mq          = 0;
    int wraps_seen  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_next(input int q, input bit e, input bit u, input bit l, input int lv);
        if (l) return (lv < MOD) ? lv : MOD - 1;
        if (e && u) return (q == MOD - 1) ? 0 : q + 1;
        if (e) return (q == 0) ? MOD - 1 : q - 1;
        return q;
    endfunction

    task automatic drive(input bit e, input bit u, input bit l, input int lv);
        bus.en       = e;
        bus.up       = u;
        bus.load     = l;
        bus.load_val = 4'(lv);
    endtask

    task automatic step(input bit e, input bit u, input bit l, input int lv);
        int   n;
        bit   tc_exp;
        exp_t got;
        drive(e, u, l, lv);
        #1;
        n      = model_next(mq, e, u, l, lv);
        tc_exp = e && !l && (u ? (mq == MOD - 1) : (mq == 0));
        chk("tc", 32'(bus.tc), 32'(tc_exp));
        chk("j_out", 32'(bus.j_out), 32'((n & ~mq) & 15));
        chk("k_out", 32'(bus.k_out), 32'((~n & mq) & 15));
        chk("jk_exclusive", 32'(bus.j_out & bus.k_out), 32'(0));
        sb.push_back('{q: n, w: tc_exp});
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("q", 32'(bus.q), 32'(got.q));
        chk("wrap", 32'(bus.wrap), 32'(got.w));
        if (bus.wrap === 1'b1) wraps_seen++;
        mq = n;
    endtask

    initial begin
        drive(0, 0, 0, 0);
        #1 rst = 1'b0;
        #2;
        chk("reset_q", 32'(bus.q), 32'(0));
        chk("reset_wrap", 32'(bus.wrap), 32'(0));

        // Edges while in reset must be ignored.
        drive(1, 1, 0, 0);
        @(posedge clk);
        #1;
        chk("reset_hold_q", 32'(bus.q), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        mq  = 0;

        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("idle_j", 32'(bus.j_out), 32'(0));
        chk("idle_k", 32'(bus.k_out), 32'(0));

        wraps_seen = 0;
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
        chk("up_end_q", 32'(bus.q), 32'(2));
        chk("up_wrap_count", 32'(wraps_seen), 32'(1));

        step(1, 1, 1, 0);
        wraps_seen = 0;
        step(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        #1;
        chk("down_9_j", 32'(bus.j_out), 32'(4'b0000));
        chk("down_9_k", 32'(bus.k_out), 32'(4'b0001));
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("down_end_q", 32'(bus.q), 32'(7));
        chk("down_wrap_count", 32'(wraps_seen), 32'(1));

        step(1, 1, 1, 6);
        step(1, 1, 1, 13);
        chk("load_sat_q", 32'(bus.q), 32'(9));
        step(1, 1, 1, 0);
        chk("load_zero_wrap", 32'(bus.wrap), 32'(0));
        step(0, 0, 1, 15);

        step(0, 0, 1, 7);
        drive(1, 1, 0, 0);
        #1;
        chk("exc_7_j", 32'(bus.j_out), 32'(4'b1000));
        chk("exc_7_k", 32'(bus.k_out), 32'(4'b0111));
        step(1, 1, 0, 0);
        chk("exc_7_next", 32'(bus.q), 32'(8));

        step(0, 1, 1, 9);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);

        step(0, 1, 1, 4);
        step(1, 1, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("midreset_q", 32'(bus.q), 32'(0));
        chk("midreset_wrap", 32'(bus.wrap), 32'(0));
        mq = 0;
        @(negedge clk);
        rst = 1'b1;
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("resume_q", 32'(bus.q), 32'(2));

        // A wrap pulse pending when reset hits must be discarded.
        step(0, 1, 1, 9);
        step(1, 1, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("reset_kills_wrap", 32'(bus.wrap), 32'(0));
        mq = 0;
        @(negedge clk);
        rst = 1'b1;
        step(1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
